// File: rtl/pwm_duty_meter.sv
// Duty-cycle meter for a PWM line: synchronizes the input, measures high time per
// period and reports a 0..PERIOD duty code with lock/error status.
module pwm_duty_meter #(
  parameter int PERIOD      = 10,
  parameter int DUTY_W      = 4,
  parameter int CNT_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pwm,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_valid,
  output logic              o_locked,
  output logic              o_error
);

  typedef enum logic [1:0] {SEARCH, MEASURE, STEADY} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PER_C   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  TO_C    = CNT_W'(2 * PERIOD);
  localparam logic [DUTY_W-1:0] DUTY_HI = DUTY_W'(PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sample, rise, fall;
  logic [CNT_W-1:0]       period_cnt, high_cnt;

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic              valid_d, locked_d, error_d;
  logic              steady_hi_q, steady_hi_d;

  assign sample = sync_q[SYNC_STAGES-1];
  assign rise   = sample & ~prev_q;
  assign fall   = ~sample & prev_q;

  // prev clears on reset, so a line held high through reset reads as a rising edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      prev_q <= sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else begin
      if (period_cnt != CNT_MAX)          period_cnt <= period_cnt + CNT_ONE;
      if (sample && high_cnt != CNT_MAX)  high_cnt   <= high_cnt + CNT_ONE;
    end
  end

  // Rise evaluation sees the counters before their reload; rise beats timeout.
  always_comb begin
    state_d     = state_q;
    duty_d      = o_duty;
    valid_d     = 1'b0;
    locked_d    = o_locked;
    error_d     = o_error;
    steady_hi_d = steady_hi_q;
    case (state_q)
      SEARCH: if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise) begin
          if (period_cnt == PER_C) begin
            duty_d   = DUTY_W'(high_cnt);
            valid_d  = 1'b1;
            locked_d = 1'b1;
            error_d  = 1'b0;
          end else begin
            locked_d = 1'b0;
            error_d  = 1'b1;
          end
        end else if (period_cnt == TO_C) begin
          state_d     = STEADY;
          duty_d      = sample ? DUTY_HI : '0;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
          error_d     = 1'b0;
          steady_hi_d = sample;
        end
      end
      STEADY: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (fall && steady_hi_q) begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= SEARCH;
      o_duty      <= '0;
      o_valid     <= 1'b0;
      o_locked    <= 1'b0;
      o_error     <= 1'b0;
      steady_hi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_duty      <= duty_d;
      o_valid     <= valid_d;
      o_locked    <= locked_d;
      o_error     <= error_d;
      steady_hi_q <= steady_hi_d;
    end
  end

endmodule
